gray_step_monitor: RTL

- Downstream consumer of the Gray-code up/down counter output.
- Samples the Gray word every enabled cycle and converts it to binary.
- Classifies each transition as up-step, down-step, hold or illegal jump, and tracks wrap-arounds, net revolutions and errors.
- Reports status to the control/debug logic that consumes the counter.

---
 rtl/gray_step_monitor.sv | 127 ++++++++++++
 1 files changed

// File: rtl/gray_step_monitor.sv
// Gray step monitor: converts each enabled Gray sample to binary and classifies the step; 1-cycle latency.
// No backpressure: en gates sampling and all state holds while it is low; clr acts regardless of en.
module gray_step_monitor #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8,
    parameter int REV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] gray_in,
    output logic [WIDTH-1:0] bin_out,
    output logic             dir_out,
    output logic             step_up,
    output logic             step_dn,
    output logic             hold,
    output logic             wrap_up,
    output logic             wrap_dn,
    output logic             err,
    output logic             fault,
    output logic [ERR_W-1:0] err_cnt,
    output logic [REV_W-1:0] rev_cnt
);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_TRACK,
        ST_FAULT
    } state_t;

    localparam logic [WIDTH-1:0] BIN_ONES = '1;
    localparam logic [WIDTH-1:0] BIN_ZERO = '0;
    localparam logic [WIDTH-1:0] BIN_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0] ERR_ONES = '1;
    localparam logic [ERR_W-1:0] ERR_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};
    localparam logic [REV_W-1:0] REV_ONE  = {{(REV_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [WIDTH-1:0] w_nb;
    logic [WIDTH-1:0] w_delta;
    logic             w_is_up;
    logic             w_is_dn;
    logic             w_is_hold;
    logic [ERR_W-1:0] w_err_base;
    logic [REV_W-1:0] w_rev_base;

    // Each binary bit is the XOR of all Gray bits at and above its position.
    always_comb begin
        w_nb = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_nb[i] = ^(gray_in >> i);
        end
    end

    assign w_delta   = w_nb - bin_out;
    assign w_is_up   = (w_delta == BIN_ONE);
    assign w_is_dn   = (w_delta == BIN_ONES);
    assign w_is_hold = (w_delta == BIN_ZERO);

    // A same-edge clear takes effect first, so any event on that edge counts from zero.
    assign w_err_base = clr ? '0 : err_cnt;
    assign w_rev_base = clr ? '0 : rev_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_INIT;
            bin_out <= '0;
            dir_out <= 1'b1;
            step_up <= 1'b0;
            step_dn <= 1'b0;
            hold    <= 1'b0;
            wrap_up <= 1'b0;
            wrap_dn <= 1'b0;
            err     <= 1'b0;
            fault   <= 1'b0;
            err_cnt <= '0;
            rev_cnt <= '0;
        end else begin
            step_up <= 1'b0;
            step_dn <= 1'b0;
            hold    <= 1'b0;
            wrap_up <= 1'b0;
            wrap_dn <= 1'b0;
            err     <= 1'b0;

            if (clr) begin
                fault   <= 1'b0;
                err_cnt <= '0;
                rev_cnt <= '0;
                if (r_state != ST_INIT) begin
                    r_state <= ST_TRACK;
                end
            end

            if (en) begin
                bin_out <= w_nb;
                // The first sample after reset only primes the reference word.
                if (r_state == ST_INIT) begin
                    r_state <= ST_TRACK;
                end else if (w_is_up) begin
                    step_up <= 1'b1;
                    dir_out <= 1'b1;
                    if (bin_out == BIN_ONES) begin
                        wrap_up <= 1'b1;
                        rev_cnt <= w_rev_base + REV_ONE;
                    end
                end else if (w_is_dn) begin
                    step_dn <= 1'b1;
                    dir_out <= 1'b0;
                    if (bin_out == BIN_ZERO) begin
                        wrap_dn <= 1'b1;
                        rev_cnt <= w_rev_base - REV_ONE;
                    end
                end else if (w_is_hold) begin
                    hold <= 1'b1;
                end else begin
                    err     <= 1'b1;
                    fault   <= 1'b1;
                    r_state <= ST_FAULT;
                    err_cnt <= (w_err_base == ERR_ONES) ? w_err_base : w_err_base + ERR_ONE;
                end
            end
        end
    end

endmodule
